// File: rtl/ws_pkg.sv
// Shared types and default geometry for the weight-stationary array and its controller.
package ws_pkg;
  localparam int DEF_ROWS      = 8;
  localparam int DEF_COLS      = 8;
  localparam int DEF_CNT_WIDTH = 8;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} ws_state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic w_load_en;
    logic ifmap_rd_en;
    logic pe_en;
  } ws_ctrl_t;

  function automatic ws_ctrl_t ctrl_decode(input ws_state_e s);
    ws_ctrl_t c;
    c.busy        = (s != IDLE);
    c.done        = (s == DONE);
    c.w_load_en   = (s == LOAD_W);
    c.ifmap_rd_en = (s == STREAM);
    c.pe_en       = (s == STREAM) || (s == DRAIN);
    return c;
  endfunction
endpackage

// File: rtl/ws_valid_delay.sv
// Fixed-depth 1-bit valid delay line; async clear on reset, sync flush on job abort.
module ws_valid_delay #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic flush_i,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        vld_pipe <= '0;
    else if (flush_i) vld_pipe <= '0;
    else              vld_pipe <= (vld_pipe << 1) | DEPTH'(d_i);
  end

  assign q_o = vld_pipe[DEPTH-1];
endmodule

// File: rtl/ws_array_controller.sv
// Weight-stationary array sequencer: load weights, stream ifmaps, drain psums.
// Define WS_CTRL_PERF_CNT_EN to build the saturating busy-cycle counter.
module ws_array_controller
  import ws_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CNT_WIDTH-1:0]    cfg_num_vecs_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    w_load_en_o,
  output logic [$clog2(ROWS)-1:0] w_row_o,
  output logic                    ifmap_rd_en_o,
  output logic                    pe_en_o,
  output logic                    psum_valid_o,
  output logic [31:0]             perf_cycles_o
);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(ROWS + COLS);
  // Phase counter must hold the longest of ROWS, N and ROWS+COLS-1.
  localparam int CW = (CNT_WIDTH > DW) ? CNT_WIDTH : DW;

  ws_state_e            state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] num_vecs, num_vecs_nxt;
  ws_ctrl_t             ctrl, ctrl_nxt;
  logic [RW-1:0]        w_row, w_row_nxt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= '0;
      num_vecs <= '0;
      ctrl     <= '0;
      w_row    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      num_vecs <= num_vecs_nxt;
      ctrl     <= ctrl_nxt;
      w_row    <= w_row_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CW'(1);
    num_vecs_nxt = num_vecs;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start_i && !abort_i) begin
          state_nxt    = LOAD_W;
          num_vecs_nxt = cfg_num_vecs_i;
        end
      end
      LOAD_W: if (cnt == CW'(ROWS - 1)) begin
        cnt_nxt   = '0;
        state_nxt = (num_vecs != '0) ? STREAM : DONE;
      end
      STREAM: if (cnt == CW'(num_vecs) - CW'(1)) begin
        cnt_nxt   = '0;
        state_nxt = DRAIN;
      end
      DRAIN: if (cnt == CW'(ROWS + COLS - 2)) begin
        cnt_nxt   = '0;
        state_nxt = DONE;
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    if (abort_i && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
    // Outputs are decoded from the next state so they leave flops directly.
    ctrl_nxt  = ctrl_decode(state_nxt);
    w_row_nxt = (state_nxt == LOAD_W) ? cnt_nxt[RW-1:0] : '0;
  end

  assign busy_o        = ctrl.busy;
  assign done_o        = ctrl.done;
  assign w_load_en_o   = ctrl.w_load_en;
  assign w_row_o       = w_row;
  assign ifmap_rd_en_o = ctrl.ifmap_rd_en;
  assign pe_en_o       = ctrl.pe_en;

  ws_valid_delay #(.DEPTH(ROWS)) u_psum_vld (
    .clk     (clk),
    .nrst    (nrst),
    .flush_i (abort_i && ctrl.busy),
    .d_i     (ctrl.ifmap_rd_en),
    .q_o     (psum_valid_o)
  );

`ifdef WS_CTRL_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      perf_cnt <= '0;
    else if ((state == IDLE) && start_i && !abort_i)
      perf_cnt <= '0;
    else if (ctrl.busy && (perf_cnt != '1))
      perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_cycles_o = perf_cnt;
`else
  assign perf_cycles_o = '0;
`endif
endmodule

// File: tb/tb_ws_array_controller.sv
// Directed + randomized bench for ws_array_controller against a per-cycle timeline model.
module tb_ws_array_controller;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int CW = 8;
  localparam int RW = $clog2(R);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [CW-1:0] cfg_num_vecs_i = '0;
  logic          busy_o, done_o, w_load_en_o, ifmap_rd_en_o, pe_en_o, psum_valid_o;
  logic [RW-1:0] w_row_o;
  logic [31:0]   perf_cycles_o;

  int checks = 0;
  int errors = 0;
  int perf_model = 0;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          wl;
    logic          rd;
    logic          pe;
    logic          pv;
    logic [RW-1:0] row;
  } exp_t;

  ws_array_controller #(.ROWS(R), .COLS(C), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .cfg_num_vecs_i (cfg_num_vecs_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .w_load_en_o    (w_load_en_o),
    .w_row_o        (w_row_o),
    .ifmap_rd_en_o  (ifmap_rd_en_o),
    .pe_en_o        (pe_en_o),
    .psum_valid_o   (psum_valid_o),
    .perf_cycles_o  (perf_cycles_o)
  );

  always #5 clk = ~clk;

  // Cycle (relative to the start cycle t=0) at which done_o pulses.
  function automatic int job_len(input int n);
    return (n == 0) ? R + 1 : 2 * R + n + C;
  endfunction

  function automatic exp_t model(input int t, input int n, input bit zero);
    exp_t e;
    int   dt;
    e  = '0;
    dt = job_len(n);
    if (!zero) begin
      e.busy = (t >= 1) && (t <= dt);
      e.done = (t == dt);
      e.wl   = (t >= 1) && (t <= R);
      e.row  = e.wl ? RW'(t - 1) : '0;
      e.rd   = (n > 0) && (t > R) && (t <= R + n);
      e.pe   = (n > 0) && (t > R) && (t < dt);
      e.pv   = (n > 0) && (t > 2 * R) && (t <= 2 * R + n);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_cycle(input string ph, input int t, input int n, input bit zero);
    exp_t e;
    e = model(t, n, zero);
    chk($sformatf("%s t=%0d busy", ph, t), 32'(busy_o), 32'(e.busy));
    chk($sformatf("%s t=%0d done", ph, t), 32'(done_o), 32'(e.done));
    chk($sformatf("%s t=%0d wload", ph, t), 32'(w_load_en_o), 32'(e.wl));
    chk($sformatf("%s t=%0d wrow", ph, t), 32'(w_row_o), 32'(e.row));
    chk($sformatf("%s t=%0d rd", ph, t), 32'(ifmap_rd_en_o), 32'(e.rd));
    chk($sformatf("%s t=%0d pe", ph, t), 32'(pe_en_o), 32'(e.pe));
    chk($sformatf("%s t=%0d pvalid", ph, t), 32'(psum_valid_o), 32'(e.pv));
`ifdef WS_CTRL_PERF_CNT_EN
    chk($sformatf("%s t=%0d perf", ph, t), perf_cycles_o, 32'(perf_model));
`else
    chk($sformatf("%s t=%0d perf", ph, t), perf_cycles_o, 32'd0);
`endif
  endtask

  // Entered and left at posedge+1. abort_at/rst_at < 0 disables that event.
  task automatic run_job(input string ph, input int n, input int abort_at, input int rst_at,
                         input int tail, input bit hold);
    int   last_t;
    bit   killed;
    exp_t e;
    last_t = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at : job_len(n));
    killed = 1'b0;
    for (int t = 0; t <= last_t + tail; t++) begin
      if (t == 0) begin
        start_i        = 1'b1;
        cfg_num_vecs_i = CW'(n);
      end else if (t <= last_t) begin
        start_i        = hold ? 1'b1 : 1'($urandom_range(0, 1));
        cfg_num_vecs_i = CW'($urandom);
      end else begin
        start_i = 1'b0;
      end
      abort_i = (t == abort_at);
      if (t == rst_at) begin
        nrst = 1'b0;
        #1;
        perf_model = 0;
        killed     = 1'b1;
        check_cycle({ph, "/rst"}, t, n, 1'b1);
        @(posedge clk);
        #1;
        nrst = 1'b1;
      end else begin
        @(negedge clk);
        check_cycle(ph, t, n, killed || ((abort_at > 0) && (t > abort_at)));
        e = model(t, n, killed || ((abort_at > 0) && (t > abort_at)));
        if (t == 0)      perf_model = 0;
        else if (e.busy) perf_model++;
        @(posedge clk);
        #1;
      end
    end
    abort_i = 1'b0;
    if (!hold) start_i = 1'b0;
  endtask

  initial begin
    int n, ab, tl;
    #2;
    check_cycle("reset", 0, 0, 1'b1);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    check_cycle("idle", 0, 0, 1'b1);
    @(posedge clk);
    #1;

    run_job("n4", 4, -1, -1, 3, 1'b0);
    run_job("n0", 0, -1, -1, 2, 1'b0);
    run_job("abort11", 4, 11, -1, 2, 1'b0);
    run_job("after_abort", 4, -1, -1, 1, 1'b0);
    run_job("hold1", 4, -1, -1, 0, 1'b1);
    run_job("hold2", 4, -1, -1, 2, 1'b0);
    run_job("rst20", 4, -1, 20, 2, 1'b0);
    run_job("after_rst", 4, -1, -1, 1, 1'b0);

    // Abort and start together in IDLE: abort wins.
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    check_cycle("absidle0", 0, 0, 1'b1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk);
    check_cycle("absidle1", 0, 0, 1'b1);
    @(posedge clk);
    #1;

    run_job("nmax", (1 << CW) - 1, -1, -1, 1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      n  = $urandom_range(0, 12);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, job_len(n))) : -1;
      tl = $urandom_range(0, 3);
      run_job($sformatf("rnd%0d", k), n, ab, -1, tl, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
